// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking entry controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    OPEN   = 2'd2,
    LOCKED = 2'd3
  } park_state_t;

  localparam int unsigned DEF_PW_LEN     = 6;
  localparam logic [7:0]  DEF_PASSWORD   = 8'b0000_1011;
  localparam int unsigned DEF_CAPACITY   = 7;
  localparam int unsigned DEF_TICK_DIV   = 20000000;
  localparam int unsigned DEF_GATE_TICKS = 10;
  localparam int unsigned DEF_MAX_FAIL   = 3;
  localparam int unsigned DEF_LOCK_TICKS = 50;

  // Largest of three values; sizes the shared tick timer / fail counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_pulse.sv
// Button conditioner: 2-FF synchronizer plus rising-edge detect, all sampled
// on tick_en, producing a single-cycle pulse coincident with tick_en.
module key_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_en,
  input  logic key,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronize and remember previous level, advancing only on ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else if (tick_en) begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = tick_en & sync2 & ~prev;

endmodule

// File: rtl/parking_ctrl_gen.sv
// Parking entry controller: password-gated entry, occupancy tracking and
// optional lockout after repeated wrong codes (enable with PARK_LOCKOUT_EN).
module parking_ctrl_gen
  import parking_pkg::*;
#(
  parameter int unsigned          PW_LEN     = DEF_PW_LEN,
  parameter logic [PW_LEN-1:0]    PASSWORD   = PW_LEN'(DEF_PASSWORD),
  parameter int unsigned          CAPACITY   = DEF_CAPACITY,
  parameter int unsigned          TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned          GATE_TICKS = DEF_GATE_TICKS,
  parameter int unsigned          MAX_FAIL   = DEF_MAX_FAIL,
  parameter int unsigned          LOCK_TICKS = DEF_LOCK_TICKS
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic       zero,
  input  logic       one,
  input  logic       v,
  input  logic       exit_car,
  output logic       gate,
  output logic       bulb,
  output logic       full,
  output logic       locked,
  output logic [3:0] occupancy,
  output logic [3:0] digits
);

  localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // One width covers the gate/lock tick timer and the fail counter.
  localparam int unsigned TW  = $clog2(max3(GATE_TICKS, LOCK_TICKS, MAX_FAIL) + 1);

  park_state_t       state;
  park_state_t       state_next;
  logic [TCW-1:0]    tick_cnt;
  logic              tick_en;
  logic              v_s1;
  logic              v_s;
  logic              zero_p;
  logic              one_p;
  logic              exit_p;
  logic [PW_LEN-1:0] shift_reg;
  logic [PW_LEN-1:0] shift_next;
  logic [3:0]        digit_cnt;
  logic [3:0]        digits_next;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_next;
  logic              occ_inc;
  logic              occ_dec;
`ifdef PARK_LOCKOUT_EN
  logic [TW-1:0]     fail_cnt;
  logic [TW-1:0]     fail_next;
`endif

  assign tick_en = (tick_cnt == TCW'(TICK_DIV - 1));

  // Free-running tick prescaler.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else        tick_cnt <= tick_en ? '0 : tick_cnt + TCW'(1);
  end

  // Vehicle sensor: level only, synchronized on ticks.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      v_s1 <= 1'b0;
      v_s  <= 1'b0;
    end else if (tick_en) begin
      v_s1 <= v;
      v_s  <= v_s1;
    end
  end

  key_pulse u_zero (.clk(clk_100Mhz), .rst_n(reset), .tick_en(tick_en), .key(zero),     .pulse(zero_p));
  key_pulse u_one  (.clk(clk_100Mhz), .rst_n(reset), .tick_en(tick_en), .key(one),      .pulse(one_p));
  key_pulse u_exit (.clk(clk_100Mhz), .rst_n(reset), .tick_en(tick_en), .key(exit_car), .pulse(exit_p));

  // State and datapath registers.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      digit_cnt <= '0;
      timer     <= '0;
`ifdef PARK_LOCKOUT_EN
      fail_cnt  <= '0;
`endif
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      digit_cnt <= digits_next;
      timer     <= timer_next;
`ifdef PARK_LOCKOUT_EN
      fail_cnt  <= fail_next;
`endif
    end
  end

  // Next-state and datapath updates, evaluated only on ticks.
  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    digits_next = digit_cnt;
    timer_next  = timer;
    occ_inc     = 1'b0;
`ifdef PARK_LOCKOUT_EN
    fail_next   = fail_cnt;
`endif
    if (tick_en) begin
      unique case (state)
        IDLE: begin
          timer_next = '0;
          if (v_s && !full) state_next = ENTRY;
        end
        ENTRY: begin
          timer_next = '0;
          if (!v_s) begin
            state_next  = IDLE;
            digits_next = '0;
          end else if (digit_cnt == 4'(PW_LEN)) begin
            digits_next = '0;
            if (shift_reg == PASSWORD) begin
              state_next = OPEN;
`ifdef PARK_LOCKOUT_EN
              fail_next  = '0;
            end else if (fail_cnt == TW'(MAX_FAIL - 1)) begin
              fail_next  = fail_cnt + TW'(1);
              state_next = LOCKED;
            end else begin
              fail_next  = fail_cnt + TW'(1);
`endif
            end
          end else if (zero_p ^ one_p) begin
            shift_next  = {shift_reg[PW_LEN-2:0], one_p};
            digits_next = digit_cnt + 4'd1;
          end
        end
        OPEN: begin
          if (!v_s) begin
            occ_inc    = 1'b1;
            state_next = IDLE;
          end else if (timer == TW'(GATE_TICKS - 1)) begin
            state_next = IDLE;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
        LOCKED: begin
`ifdef PARK_LOCKOUT_EN
          if (timer == TW'(LOCK_TICKS - 1)) begin
            state_next = IDLE;
            fail_next  = '0;
          end else begin
            timer_next = timer + TW'(1);
          end
`else
          state_next = IDLE;
`endif
        end
      endcase
    end
  end

  assign occ_dec = exit_p && (occupancy != 4'd0);

  // Occupancy: saturating, simultaneous entry and exit cancel.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else if (occ_inc && !occ_dec) begin
      if (occupancy != 4'(CAPACITY)) occupancy <= occupancy + 4'd1;
    end else if (occ_dec && !occ_inc) begin
      occupancy <= occupancy - 4'd1;
    end
  end

  assign full   = (occupancy == 4'(CAPACITY));
  assign gate   = (state == OPEN);
  assign bulb   = (state == ENTRY);
  assign digits = digit_cnt;
`ifdef PARK_LOCKOUT_EN
  assign locked = (state == LOCKED);
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_parking_ctrl_gen.sv
// Scoreboard bench for parking_ctrl_gen (TICK_DIV=4, so one tick = 4 clocks).
module tb_parking_ctrl_gen;

  typedef struct {
    logic       gate;
    logic       bulb;
    logic       full;
    logic       locked;
    logic [3:0] occ;
    logic [3:0] dig;
    int         dt;
    string      name;
  } snap_t;

  localparam logic [5:0] PW    = 6'b001011;
  localparam logic [5:0] WRONG = 6'b111111;

  logic clk = 1'b0;
  logic reset, zero, one, v, exit_car;
  logic gate, bulb, full, locked;
  logic [3:0] occupancy, digits;

  snap_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int m_gate, m_bulb, m_locked, m_occ, m_dig;
`ifdef PARK_LOCKOUT_EN
  int m_fail = 0;
`endif

  parking_ctrl_gen #(.TICK_DIV(4)) dut (
    .clk_100Mhz(clk), .reset(reset), .zero(zero), .one(one), .v(v),
    .exit_car(exit_car), .gate(gate), .bulb(bulb), .full(full),
    .locked(locked), .occupancy(occupancy), .digits(digits)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output vector consumes one expected snapshot.
  initial begin
    logic [13:0] last_seen;
    logic [13:0] cur;
    logic [13:0] want;
    int last_cyc;
    snap_t s;
    last_seen = '1;
    last_cyc  = 0;
    forever begin
      @(negedge clk);
      cur = {gate, bulb, full, locked, occupancy, digits};
      if (cur !== last_seen) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change got g/b/f/l/occ/dig=%b/%b/%b/%b/%0d/%0d (nothing expected)",
                   gate, bulb, full, locked, occupancy, digits);
        end else begin
          s = exp_q.pop_front();
          want = {s.gate, s.bulb, s.full, s.locked, s.occ, s.dig};
          if (cur !== want) begin
            fails++;
            $display("FAIL %s got g/b/f/l/occ/dig=%b/%b/%b/%b/%0d/%0d expected %b/%b/%b/%b/%0d/%0d",
                     s.name, gate, bulb, full, locked, occupancy, digits,
                     s.gate, s.bulb, s.full, s.locked, s.occ, s.dig);
          end
          if (s.dt >= 0) begin
            tests++;
            if (cyc - last_cyc != s.dt) begin
              fails++;
              $display("FAIL %s_timing got %0d cycles expected %0d", s.name, cyc - last_cyc, s.dt);
            end
          end
        end
        last_seen = cur;
        last_cyc  = cyc;
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n * 4) @(posedge clk);
  endtask

  task automatic expect_now(input int dt, input string name);
    snap_t s;
    s.gate   = m_gate[0];
    s.bulb   = m_bulb[0];
    s.locked = m_locked[0];
    s.occ    = 4'(m_occ);
    s.dig    = 4'(m_dig);
    s.full   = (m_occ == 7);
    s.dt     = dt;
    s.name   = name;
    exp_q.push_back(s);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout got %0d pending expected 0 (next=%s)", exp_q.size(), exp_q[0].name);
      exp_q.delete();
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  // which: 0 = zero, 1 = one, 2 = exit_car, 3 = zero and one together
  task automatic press(input int which);
    zero     = (which == 0 || which == 3);
    one      = (which == 1 || which == 3);
    exit_car = (which == 2);
    ticks(3);
    zero = 1'b0; one = 1'b0; exit_car = 1'b0;
    ticks(3);
  endtask

  task automatic enter_code(input logic [5:0] code, input bit ok);
    for (int unsigned i = 0; i < 6; i++) begin
      m_dig = int'(i) + 1;
      expect_now(-1, "digit");
    end
    m_dig = 0;
    if (ok) begin
      m_gate = 1; m_bulb = 0;
`ifdef PARK_LOCKOUT_EN
      m_fail = 0;
`endif
      expect_now(4, "open");
    end else begin
`ifdef PARK_LOCKOUT_EN
      m_fail++;
      if (m_fail == 3) begin
        m_fail = 0; m_bulb = 0; m_locked = 1;
        expect_now(4, "lock");
      end else begin
        expect_now(4, "retry");
      end
`else
      expect_now(4, "retry");
`endif
    end
    for (int unsigned i = 0; i < 6; i++) press(int'(code[5 - i]));
    wait_drain(80);
  endtask

  initial begin
    reset = 1'b0; zero = 1'b0; one = 1'b0; v = 1'b0; exit_car = 1'b0;
    m_gate = 0; m_bulb = 0; m_locked = 0; m_occ = 0; m_dig = 0;
    expect_now(-1, "reset_state");
    ticks(2);
    @(negedge clk) reset = 1'b1;
    wait_drain(20);

    // exit at empty lot
    press(2);
    ticks(2);
    check("exit_at_zero", int'(occupancy), 0);

    // correct code, car passes
    v = 1'b1; m_bulb = 1; expect_now(-1, "entry"); wait_drain(40);
    enter_code(PW, 1);
    v = 1'b0; m_gate = 0; m_occ = 1; expect_now(-1, "car_in"); wait_drain(40);

    // correct code, car never passes: gate times out
    ticks(2);
    v = 1'b1; m_bulb = 1; expect_now(-1, "entry2"); wait_drain(40);
    enter_code(PW, 1);
    m_gate = 0; expect_now(40, "gate_timeout");
    m_bulb = 1; expect_now(4, "reentry");
    wait_drain(100);

    // three wrong codes
    for (int k = 0; k < 3; k++) enter_code(WRONG, 0);
`ifdef PARK_LOCKOUT_EN
    m_locked = 0; expect_now(200, "unlock");
    m_bulb = 1; expect_now(4, "reentry_after_lock");
    wait_drain(300);
`else
    check("locked_tied_low", int'(locked), 0);
`endif

    // both digit buttons on the same tick, then a single digit
    press(3);
    ticks(2);
    check("both_pressed_digits", int'(digits), 0);
    m_dig = 1; expect_now(-1, "single_digit");
    press(1);
    wait_drain(40);

    // vehicle leaves mid-entry
    v = 1'b0; m_dig = 0; m_bulb = 0; expect_now(-1, "abort"); wait_drain(40);

    // fill the lot
    for (int n = 2; n <= 7; n++) begin
      ticks(2);
      v = 1'b1; m_bulb = 1; expect_now(-1, "entry_fill"); wait_drain(40);
      enter_code(PW, 1);
      v = 1'b0; m_gate = 0; m_occ = n; expect_now(-1, "car_in_fill"); wait_drain(40);
    end
    check("full_flag", int'(full), 1);
    v = 1'b1;
    ticks(6);
    check("full_no_bulb", int'(bulb), 0);
    check("full_no_gate", int'(gate), 0);
    v = 1'b0;
    ticks(3);
    m_occ = 6; expect_now(-1, "exit_dec");
    press(2);
    wait_drain(40);

    // reset while the gate is open
    ticks(2);
    v = 1'b1; m_bulb = 1; expect_now(-1, "entry_rst"); wait_drain(40);
    enter_code(PW, 1);
    m_gate = 0; m_bulb = 0; m_occ = 0; m_dig = 0; expect_now(-1, "reset_async");
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("gate_async_reset", int'(gate), 0);
    check("occ_async_reset", int'(occupancy), 0);
    ticks(2);
    m_bulb = 1; expect_now(-1, "entry_after_reset");
    @(negedge clk) reset = 1'b1;
    wait_drain(40);
    v = 1'b0; m_bulb = 0; expect_now(-1, "idle_final"); wait_drain(40);
    check("occ_after_reset", int'(occupancy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parking_ctrl_gen.md
PARKING_CTRL_GEN -- requirements
Module: parking_ctrl_gen

Interface
REQ-001 Parameter PW_LEN, default 6: password length in digits, legal range 2..8.
REQ-002 Parameter PASSWORD, default 6'b001011: expected digit sequence, first digit entered is the MSB.
REQ-003 Parameter CAPACITY, default 7: number of parking slots, legal range 1..15.
REQ-004 Parameter TICK_DIV, default 20000000: clk_100Mhz cycles per tick (5 Hz at 100 MHz).
REQ-005 Parameter GATE_TICKS, default 10: number of ticks the gate stays open.
REQ-006 Parameter MAX_FAIL, default 3: consecutive wrong entries that trigger lockout.
REQ-007 Parameter LOCK_TICKS, default 50: lockout duration in ticks.
REQ-008 clk_100Mhz  in  1  single system clock; all logic on its rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 zero, one  in  1 each  raw push-button digit levels, asynchronous.
REQ-011 v  in  1  vehicle present at entry, level, asynchronous.
REQ-012 exit_car  in  1  vehicle leaving, level, asynchronous.
REQ-013 gate  out  1  entry gate open.
REQ-014 bulb  out  1  vehicle waiting for entry.
REQ-015 full  out  1  occupancy equals CAPACITY.
REQ-016 locked  out  1  lockout active.
REQ-017 occupancy  out  4  cars currently inside.
REQ-018 digits  out  4  number of digits entered so far, for the seven-segment display.

Function
REQ-019 Internal counter shall emit a one-cycle tick_en every TICK_DIV cycles; all FSM, counter and input-sampling updates shall occur only on tick_en.
REQ-020 zero, one and exit_car shall each pass through a 2-FF synchronizer and a rising-edge detector clocked on tick_en, giving a one-tick pulse per press; v shall be 2-FF synchronized only.
REQ-021 FSM states: IDLE, ENTRY, OPEN, LOCKED.
REQ-022 IDLE: gate=0. If v=1 and full=0, go to ENTRY. If full=1, v is ignored and bulb=0.
REQ-023 ENTRY: bulb=1. A zero or one pulse shifts the digit into the shift register and increments digits. If both pulses arrive on the same tick, both are ignored.
REQ-024 ENTRY: when digits reaches PW_LEN, compare on the next tick. On a match, go to OPEN and clear fail_cnt. On a mismatch, increment fail_cnt, clear digits, and stay in ENTRY; if fail_cnt reaches MAX_FAIL, go to LOCKED instead.
REQ-025 ENTRY: if v falls, abort to IDLE, clear digits, and leave fail_cnt unchanged.
REQ-026 OPEN: gate=1, bulb=0. A falling edge of v (car passed) increments occupancy and returns to IDLE. If GATE_TICKS elapse with v still 1, return to IDLE with no increment.
REQ-027 LOCKED: locked=1, gate=0, digit pulses ignored. After LOCK_TICKS ticks, go to IDLE and clear fail_cnt.
REQ-028 An exit_car pulse decrements occupancy in any state; it is ignored at 0. A simultaneous increment and decrement leaves occupancy unchanged.
REQ-029 occupancy shall saturate at CAPACITY and never wrap; full is combinational from occupancy.

Reset
REQ-030 reset low shall immediately force: state=IDLE, gate=0, bulb=0, locked=0, occupancy=0, digits=0, fail_cnt=0, shift register=0, tick counter=0, synchronizers=0.
REQ-031 Reset asserted mid-operation (OPEN, LOCKED) shall abandon that operation with no occupancy change on release.

Configuration
REQ-032 With PARK_LOCKOUT_EN defined, LOCKED, fail_cnt and MAX_FAIL/LOCK_TICKS behaviour are present.
REQ-033 Without PARK_LOCKOUT_EN, a mismatch only clears digits, LOCKED is unreachable, and locked is tied to 0.

Structure
REQ-034 Package parking_pkg shall hold the FSM state encoding and the default parameter constants.
REQ-035 Sub-module key_pulse shall implement the synchronizer plus tick-qualified edge detect; it is instantiated three times (zero, one, exit_car).

Verification
REQ-036 TICK_DIV=4, v=1, press sequence 0,0,1,0,1,1 -> gate=1 on the tick after the 6th digit; drop v -> occupancy 0->1, gate=0.
REQ-037 Enter 1,1,1,1,1,1 three times with v=1 -> locked=1 for exactly 50 ticks, then IDLE. Repeat without PARK_LOCKOUT_EN -> locked stays 0.
REQ-038 Fill occupancy to 7 -> full=1; v=1 -> bulb=0 and no ENTRY. One exit_car pulse -> occupancy 6, full=0.
REQ-039 exit_car at occupancy 0 -> stays 0. zero and one pressed on the same tick -> digits unchanged.
REQ-040 Assert reset in OPEN after 3 ticks -> gate=0 asynchronously, occupancy=0, state IDLE on release.
